fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC, forms the next PC from the branch/jump decision of the instruction currently in D, reads instruction memory and loads the F/D pipeline register. It sits directly upstream of the D-stage decoder:
- It consumes the decoder's `NPCOp` code.
- It returns the resolved `bgez` condition used for `bgezalc` write-back.
- It annuls the delay slot of an untaken `bgezall`.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value after reset and base address of instruction memory.
- `IM_AW`, 12, instruction-memory word-address width; valid fetch range is [PC_RESET, PC_RESET + 4·2^IM_AW).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard-unit stall; freezes PC and F/D.
- `npc_op` input 5: D-stage next-PC code: 0 = pc+4, 1 = beq, 2 = jal, 3 = jr, 4 = bgezall, 5 = bgezalc; any other value is treated as 0.
- `d_pc` input 32: PC of the instruction in D.
- `d_imm16` input 16: D-stage imm16.
- `d_imm26` input 26: D-stage imm26.
- `d_rs_val` input 32: forwarded GPR[rs] for the D instruction.
- `d_rt_val` input 32: forwarded GPR[rt] for the D instruction.
- `imem_addr` output IM_AW: word address `(f_pc - PC_RESET) >> 2`, truncated to IM_AW bits.
- `imem_rdata` input 32: combinational instruction-memory read data.
- `f_pc` output 32: current fetch PC.
- `d_bgez_con` output 1: `$signed(d_rs_val) >= 0`; drives the decoder's bgezalc condition.
- `fd_instr` output 32: F/D instruction register.
- `fd_pc` output 32: F/D PC register.
- `fd_pc8` output 32: `fd_pc + 8`, combinational from `fd_pc`.
- `fd_valid` output 1: F/D holds a real fetched instruction.

## Operation
- Branch target: `bt = d_pc + 4 + (sext32(d_imm16) << 2)`, computed with 32-bit wrap-around arithmetic.
- Jump target: `jt = {d_pc[31:28], d_imm26, 2'b00}`.
- Next PC, `npc`, selected by `npc_op`:
  - 0: `f_pc + 4`.
  - 1: `bt` if `d_rs_val == d_rt_val`, else `f_pc + 4`.
  - 2: `jt`.
  - 3: `d_rs_val`, used unmodified with no alignment check.
  - 4 or 5: `bt` if `d_bgez_con`, else `f_pc + 4`.
- Delay slot: the instruction in F while a branch or jump is in D is the delay slot. It always proceeds into D, with one exception: `npc_op == 4` with `d_bgez_con == 0` is an annul.
- On annul, F/D loads `fd_instr = 0`, `fd_valid = 0`, `fd_pc = f_pc`. The PC still advances to `f_pc + 4`.
- Range check: if `f_pc` is outside the valid range or `f_pc[1:0] != 0`, the fetched word is replaced by 0 and `fd_valid` loads 0. The PC still advances normally.
- Stall: when `stall = 1`, the PC and all F/D registers hold. No redirect and no annul occur, because the D instruction's operands are not final. `stall` has priority over annul and redirect.
- Normal load, when `stall = 0` and there is no annul:
  - `f_pc <= npc`
  - `fd_instr <= imem_rdata` (or 0 if out of range)
  - `fd_pc <= f_pc`
  - `fd_valid <= in_range`

## Timing
- Reset (`reset = 0`, asynchronous, takes effect immediately):
  - `f_pc = PC_RESET`
  - `fd_instr = 0`
  - `fd_pc = 0`
  - `fd_valid = 0`
- After reset release, the first rising edge loads the instruction at PC_RESET into F/D.
- Fetch latency: one cycle from `f_pc` to `fd_instr`. `imem_rdata` is sampled in the same cycle that `imem_addr` is driven.
- Redirect: a branch or jump in D during cycle n sets `f_pc = target` after edge n. The target reaches F/D after edge n+1.
- `d_bgez_con`, `npc` and `fd_pc8` are purely combinational. They have no registered delay.
- Reset mid-operation discards any pending redirect, annul or stall immediately.
- Stall held for k cycles freezes all outputs for k edges. Fetch resumes with the same `f_pc` on the first edge after `stall` falls.

## Test plan
- **Reset and sequential fetch:** hold `reset = 0` for 2 cycles, then release with `npc_op = 0` and memory word i = i+1.
  - During reset, `f_pc` reads 0x3000.
  - After edges 1–3, `fd_pc` = 0x3000, 0x3004, 0x3008; `fd_instr` = 1, 2, 3; `fd_valid` = 1.
- **beq taken:** `d_pc = 0x3010`, `npc_op = 1`, `d_rs_val = d_rt_val = 5`, `d_imm16 = 0xFFFC`.
  - `f_pc` becomes 0x3004.
  - The delay slot at 0x3014 enters F/D.
- **bgezall not taken:** `npc_op = 4`, `d_rs_val = 0x8000_0000`, `f_pc = 0x3020`.
  - `d_bgez_con = 0`.
  - `fd_instr = 0`, `fd_valid = 0`, `fd_pc = 0x3020`; `f_pc` becomes 0x3024.
  - Repeat with `npc_op = 5`: no annul, `fd_valid = 1`.
- **jr/jal under stall:**
  - `npc_op = 3`, `d_rs_val = 0x3100`, `stall = 1` for 3 cycles: `f_pc` and F/D are unchanged.
  - On the cycle after `stall` falls: `f_pc = 0x3100`.
  - `npc_op = 2`, `d_imm26 = 0x0000C40`, `d_pc = 0x3000`: `f_pc = 0x0000_3100`.
- **Out-of-range fetch:** `jr` to 0x2FFC, or to `PC_RESET + 4·2^IM_AW`.
  - The next F/D has `fd_instr = 0` and `fd_valid = 0`.
  - `f_pc` advances by 4.
- **Asynchronous reset mid-redirect:** assert `reset = 0` between edges while `npc_op = 2`.
  - All outputs return to their reset values immediately, without a clock edge.
  - After release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage -- PC register, next-PC select, instruction-memory addressing and F/D register.
// Ports: clk, reset (async active-low); stall freezes PC and F/D; npc_op and d_* come from the D stage
// and select the next PC; imem_addr/imem_rdata form a combinational instruction-memory read;
// f_pc is the fetch PC; fd_instr/fd_pc/fd_pc8/fd_valid are the F/D register; d_bgez_con is the bgez condition.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [4:0]       npc_op,
  input  logic [31:0]      d_pc,
  input  logic [15:0]      d_imm16,
  input  logic [25:0]      d_imm26,
  input  logic [31:0]      d_rs_val,
  input  logic [31:0]      d_rt_val,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      f_pc,
  output logic             d_bgez_con,
  output logic [31:0]      fd_instr,
  output logic [31:0]      fd_pc,
  output logic [31:0]      fd_pc8,
  output logic             fd_valid
);
  logic [31:0] offs, pc4, bt, jt, npc;
  logic        in_range, annul;
  assign offs       = f_pc - PC_RESET;
  assign imem_addr  = offs[IM_AW+1:2];
  // Unsigned offset comparison also rejects PCs below PC_RESET, which wrap to huge offsets.
  assign in_range   = ({1'b0, offs} < (33'd4 << IM_AW)) && (f_pc[1:0] == 2'b00);
  assign d_bgez_con = ~d_rs_val[31];
  assign pc4        = f_pc + 32'd4;
  assign bt         = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign jt         = {d_pc[31:28], d_imm26, 2'b00};
  assign fd_pc8     = fd_pc + 32'd8;
  // An untaken bgezall squashes its delay slot; the PC still falls through to pc+4.
  assign annul      = (npc_op == 5'd4) && !d_bgez_con;
  always_comb begin
    npc = (npc_op == 5'd3) ? d_rs_val :
          (npc_op == 5'd2) ? jt :
          ((npc_op == 5'd1) && (d_rs_val == d_rt_val)) ? bt :
          (((npc_op == 5'd4) || (npc_op == 5'd5)) && d_bgez_con) ? bt : pc4;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc     <= PC_RESET;
      fd_instr <= 32'd0;
      fd_pc    <= 32'd0;
      fd_valid <= 1'b0;
    end else if (!stall) begin
      f_pc     <= npc;
      fd_pc    <= f_pc;
      fd_instr <= (annul || !in_range) ? 32'd0 : imem_rdata;
      fd_valid <= !annul && in_range;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized check of fetch_stage against a behavioural PC/F-D model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [4:0]  npc_op = 5'd0;
  logic [31:0] d_pc = 32'd0;
  logic [15:0] d_imm16 = 16'd0;
  logic [25:0] d_imm26 = 26'd0;
  logic [31:0] d_rs_val = 32'd0;
  logic [31:0] d_rt_val = 32'd0;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc, fd_instr, fd_pc, fd_pc8;
  logic        d_bgez_con, fd_valid;
  logic [31:0] mem [0:4095];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_on = 1'b0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .d_pc(d_pc),
    .d_imm16(d_imm16), .d_imm26(d_imm26), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .f_pc(f_pc), .d_bgez_con(d_bgez_con),
    .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_pc8(fd_pc8), .fd_valid(fd_valid)
  );

  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  // Behavioural model: PC and F/D contents computed straight from the fetch rules.
  logic [31:0] m_pc = 32'h3000;
  logic [31:0] m_fd_instr = 32'd0;
  logic [31:0] m_fd_pc = 32'd0;
  logic        m_fd_valid = 1'b0;
  logic [31:0] m_bt, m_jt, m_next;
  logic        m_ok, m_annul, m_take;

  always @(negedge reset) begin
    m_pc = 32'h3000;
    m_fd_instr = 32'd0;
    m_fd_pc = 32'd0;
    m_fd_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (reset === 1'b1 && stall === 1'b0) begin
      m_ok = (m_pc >= 32'h3000) && (m_pc < 32'h7000) && (m_pc % 4 == 0);
      m_bt = d_pc + 32'd4 + 32'($signed(d_imm16) * 4);
      m_jt = (d_pc & 32'hF000_0000) | (32'(d_imm26) * 4);
      m_take = (npc_op == 1 && d_rs_val == d_rt_val) ||
               ((npc_op == 4 || npc_op == 5) && $signed(d_rs_val) >= 0);
      m_next = (npc_op == 2) ? m_jt : (npc_op == 3) ? d_rs_val : m_take ? m_bt : m_pc + 32'd4;
      m_annul = (npc_op == 4) && ($signed(d_rs_val) < 0);
      m_fd_pc = m_pc;
      m_fd_valid = m_ok && !m_annul;
      m_fd_instr = m_fd_valid ? mem[(m_pc - 32'h3000) / 4] : 32'd0;
      m_pc = m_next;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_f_pc", f_pc, m_pc);
      chk("m_imem_addr", 32'(imem_addr), 32'(12'((m_pc - 32'h3000) / 4)));
      chk("m_bgez_con", 32'(d_bgez_con), 32'($signed(d_rs_val) >= 0));
      chk("m_fd_instr", fd_instr, m_fd_instr);
      chk("m_fd_pc", fd_pc, m_fd_pc);
      chk("m_fd_pc8", fd_pc8, m_fd_pc + 32'd8);
      chk("m_fd_valid", 32'(fd_valid), 32'(m_fd_valid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_fd(input string nm, input logic [31:0] ei, input logic [31:0] ep,
                        input logic ev, input logic [31:0] epc);
    chk({nm, "_instr"}, fd_instr, ei);
    chk({nm, "_fd_pc"}, fd_pc, ep);
    chk({nm, "_valid"}, 32'(fd_valid), 32'(ev));
    chk({nm, "_f_pc"}, f_pc, epc);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = i + 1;
    #2 reset = 1'b0;
    #1 chk_on = 1'b1;
    chk("rst_f_pc", f_pc, 32'h3000);
    chk("rst_valid", 32'(fd_valid), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick(); settle(); chk_fd("seq1", 32'd1, 32'h3000, 1'b1, 32'h3004);
    tick(); settle(); chk_fd("seq2", 32'd2, 32'h3004, 1'b1, 32'h3008);
    tick(); settle(); chk_fd("seq3", 32'd3, 32'h3008, 1'b1, 32'h300C);
    tick();
    tick(); settle(); chk("pre_beq_f_pc", f_pc, 32'h3014);
    d_pc = 32'h3010; npc_op = 5'd1; d_rs_val = 32'd5; d_rt_val = 32'd5; d_imm16 = 16'hFFFC;
    tick(); settle(); chk_fd("beq", 32'd6, 32'h3014, 1'b1, 32'h3004);
    npc_op = 5'd3; d_rs_val = 32'h3020;
    tick(); settle(); chk("jr3020_f_pc", f_pc, 32'h3020);
    npc_op = 5'd4; d_rs_val = 32'h8000_0000;
    settle(); chk("bgez_con_neg", 32'(d_bgez_con), 32'd0);
    tick(); settle(); chk_fd("bgezall_annul", 32'd0, 32'h3020, 1'b0, 32'h3024);
    npc_op = 5'd5;
    tick(); settle(); chk_fd("bgezalc_nt", 32'd10, 32'h3024, 1'b1, 32'h3028);
    npc_op = 5'd3; d_rs_val = 32'h3100; stall = 1'b1;
    repeat (3) begin
      tick(); settle(); chk_fd("stall", 32'd10, 32'h3024, 1'b1, 32'h3028);
    end
    stall = 1'b0;
    tick(); settle(); chk_fd("jr_after_stall", 32'd11, 32'h3028, 1'b1, 32'h3100);
    npc_op = 5'd2; d_imm26 = 26'h0000C40; d_pc = 32'h3000;
    tick(); settle(); chk_fd("jal", 32'h41, 32'h3100, 1'b1, 32'h3100);
    npc_op = 5'd3; d_rs_val = 32'h2FFC;
    tick(); npc_op = 5'd0;
    tick(); settle(); chk_fd("oor_low", 32'd0, 32'h2FFC, 1'b0, 32'h3000);
    npc_op = 5'd3; d_rs_val = 32'h7000;
    tick(); npc_op = 5'd0;
    tick(); settle(); chk_fd("oor_high", 32'd0, 32'h7000, 1'b0, 32'h7004);
    npc_op = 5'd2; d_pc = 32'h3000; d_imm26 = 26'h0000C40;
    settle();
    reset = 1'b0;
    #1;
    chk_fd("async_rst", 32'd0, 32'd0, 1'b0, 32'h3000);
    chk("async_rst_pc8", fd_pc8, 32'd8);
    tick();
    reset = 1'b1; npc_op = 5'd0;
    tick(); settle(); chk_fd("restart", 32'd1, 32'h3000, 1'b1, 32'h3004);
    for (int n = 0; n < 3000; n++) begin
      tick();
      mem[$urandom_range(0, 4095)] = $urandom;
      case ($urandom_range(0, 9))
        0, 7, 8, 9: npc_op = 5'd0;
        1: npc_op = 5'd1;
        2: npc_op = 5'd2;
        3: npc_op = 5'd3;
        4: npc_op = 5'd4;
        5: npc_op = 5'd5;
        default: npc_op = 5'($urandom_range(6, 31));
      endcase
      stall = ($urandom_range(0, 4) == 0);
      d_pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095);
      d_imm16 = 16'($urandom);
      d_imm26 = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(32'hBF0, 32'h1C10));
      case ($urandom_range(0, 3))
        0: d_rs_val = 32'h2F00 + 4 * $urandom_range(0, 32'h1100);
        1: d_rs_val = 32'h2F00 + 4 * $urandom_range(0, 32'h1100) + $urandom_range(1, 3);
        2: d_rs_val = $urandom;
        default: d_rs_val = $urandom | 32'h8000_0000;
      endcase
      d_rt_val = ($urandom_range(0, 1) == 0) ? d_rs_val : $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    tick();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
